// File: rtl/fifo_rd_stream_pkg.sv
// Shared constants for the async-FIFO read-side stream adapter.
package fifo_rd_stream_pkg;

    localparam int unsigned DATA_WIDTH_DEF = 8;
    localparam int unsigned CNT_W          = 2;
    localparam int unsigned OCC_W          = 3;
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(2);

endpackage : fifo_rd_stream_pkg

// File: rtl/fifo_rd_stream_if.sv
// FIFO pop side plus valid/ready stream side of the read output stage.
interface fifo_rd_stream_if
    import fifo_rd_stream_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
);

    logic                  fifo_empty_i;
    logic [DATA_WIDTH-1:0] fifo_rd_data_i;
    logic                  fifo_rd_en_o;
    logic [DATA_WIDTH-1:0] m_tdata_o;
    logic                  m_tvalid_o;
    logic                  m_tready_i;
    logic [CNT_W-1:0]      count_o;

    // Adapter view.
    modport master (
        input  fifo_empty_i,
        input  fifo_rd_data_i,
        input  m_tready_i,
        output fifo_rd_en_o,
        output m_tdata_o,
        output m_tvalid_o,
        output count_o
    );

    // FIFO core plus stream consumer view.
    modport slave (
        output fifo_empty_i,
        output fifo_rd_data_i,
        output m_tready_i,
        input  fifo_rd_en_o,
        input  m_tdata_o,
        input  m_tvalid_o,
        input  count_o
    );

endinterface : fifo_rd_stream_if

// File: rtl/fifo_rd_stream.sv
// Read-side output stage: converts the FIFO pop interface (1-cycle RAM latency)
// into a registered valid/ready stream through a 2-entry skid buffer.
module fifo_rd_stream
    import fifo_rd_stream_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic              rd_clk_i,
    input  logic              rd_rstn_i,
    fifo_rd_stream_if.master  bus
);

    logic [DATA_WIDTH-1:0] head_q, head_d;
    logic [DATA_WIDTH-1:0] tail_q, tail_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  valid_q, valid_d;
    logic                  pend_q, pend_d;

    logic                  pop_c;
    logic                  push_c;
    logic                  rd_en_c;
    logic [OCC_W-1:0]      occ_after_c;

    // Pop request: only if the word cannot overflow the buffer after this cycle's pop.
    always_comb begin
        pop_c       = valid_q & bus.m_tready_i;
        push_c      = pend_q;
        occ_after_c = OCC_W'(count_q) + OCC_W'(pend_q) - OCC_W'(pop_c);
        rd_en_c     = rd_rstn_i & ~bus.fifo_empty_i & (occ_after_c < OCC_W'(CNT_MAX));
    end

    // Skid-buffer occupancy update.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        pend_d  = rd_en_c;
        unique case (count_q)
            CNT_W'(0): begin
                if (push_c) begin
                    head_d  = bus.fifo_rd_data_i;
                    count_d = CNT_W'(1);
                end
            end
            CNT_W'(1): begin
                if (push_c && !pop_c) begin
                    tail_d  = bus.fifo_rd_data_i;
                    count_d = CNT_W'(2);
                end else if (push_c && pop_c) begin
                    head_d  = bus.fifo_rd_data_i;
                end else if (pop_c) begin
                    count_d = CNT_W'(0);
                end
            end
            CNT_W'(2): begin
                if (pop_c) begin
                    head_d  = tail_q;
                    count_d = CNT_W'(1);
                end
            end
            default: begin
                count_d = CNT_W'(0);
            end
        endcase
        valid_d = (count_d != CNT_W'(0));
    end

    always_ff @(posedge rd_clk_i) begin
        if (!rd_rstn_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            valid_q <= valid_d;
            pend_q  <= pend_d;
        end
    end

    assign bus.fifo_rd_en_o = rd_en_c;
    assign bus.m_tdata_o    = head_q;
    assign bus.m_tvalid_o   = valid_q;
    assign bus.count_o      = count_q;

endmodule : fifo_rd_stream
